uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Next-generation UART transmitter: serialises a DATA_WIDTH-bit word LSB-first with start bit,
//  optional even/odd parity and 1 or 2 stop bits. Bit period is runtime-programmable via PRESCALE.
//  Single FSM plus counters replaces the separate FSM/serializer/parity/mux split.
//  Sits between the system register file / async FIFO read side and the UART TX pad.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame (>=5)
//  PRESC_W     8  width of PRESCALE input (clock cycles per bit)
// PORTS
//  CLK         in   1           single system clock, rising edge
//  RST         in   1           asynchronous, active-high reset
//  P_DATA      in   DATA_WIDTH  parallel word, sampled on accept
//  DATA_VALID  in   1           request to send P_DATA
//  PAR_EN      in   1           1 = insert parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  STOP2       in   1           1 = two stop bits, 0 = one
//  PRESCALE    in   PRESC_W     clock cycles per bit; 0 treated as 1
//  TX_OUT      out  1           serial line, idle high, registered
//  BUSY        out  1           frame in progress, registered
//  TX_DONE     out  1           one-cycle pulse at frame end, registered
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): TX_OUT=1, BUSY=0, TX_DONE=0, FSM=IDLE, counters=0.
//  - Accept: DATA_VALID=1 while BUSY=0 at edge t -> latch P_DATA, PAR_EN, PAR_TYP, STOP2, PRESCALE.
//    From t+1: TX_OUT=0 (start), BUSY=1. DATA_VALID while BUSY=1 ignored; config changes mid-frame ignored.
//  - FSM: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
//  - Each bit held exactly P = max(PRESCALE,1) cycles; baud counter 0..P-1, advance at P-1.
//  - DATA: bit counter 0..DATA_WIDTH-1, TX_OUT = data[bit], LSB first.
//  - PARITY: TX_OUT = ^data XOR PAR_TYP (even: total ones incl. parity even).
//  - STOP: TX_OUT=1 for P cycles (STOP2=0) or 2P cycles (STOP2=1).
//  - Frame end: at edge closing last stop cycle -> IDLE, BUSY=0, TX_DONE=1 for exactly one cycle; TX_OUT stays 1.
//  - Back-to-back: DATA_VALID=1 in the TX_DONE cycle is accepted; next start bit begins the following cycle.
//    Frame length N = P*(1+DATA_WIDTH+PAR_EN+1+STOP2); min accept-to-accept period N+1 cycles.
//  - No glitches: TX_OUT changes only on bit boundaries, driven from a flop.
//  - PRESCALE wrap: counters sized PRESC_W; P = 2^PRESC_W-1 must work without overflow.
// TESTING
//  1) Reset mid-frame (during DATA bit 3) -> TX_OUT=1, BUSY=0 same cycle as RST; no TX_DONE.
//  2) P_DATA=8'hA5, PAR_EN=0, STOP2=0, PRESCALE=4 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles; BUSY high 40 cycles; TX_DONE at cycle 41.
//  3) P_DATA=8'h03, PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame 11 bits.
//  4) STOP2=1, PRESCALE=0 -> P=1; 8'hFF frame = 0,1x8,1,1; BUSY 11 cycles.
//  5) DATA_VALID held high, words 8'h11 then 8'h22 -> second start bit exactly one cycle after TX_DONE;
//     P_DATA/PRESCALE changed mid-frame do not alter the frame in flight.
//  6) PRESCALE=255, PAR_EN=1, STOP2=1 -> each bit 255 cycles; checker decodes 8'h5A correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, LSB-first payload, optional even/odd parity, 1 or 2 stop bits.
// Bit period is programmable per frame; all line/status outputs come straight from flops.
`timescale 1ns/1ps
module uart_tx_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_end;

  // presc_q is never 0 during a frame, so P-1 cannot underflow and 2^PRESC_W-1 still fits.
  assign baud_end = (baud_q == presc_q - PRESC_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    presc_d   = presc_q;
    unique case (state_q)
      StIdle: begin
        if (DATA_VALID) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
          presc_d   = (PRESCALE == '0) ? PRESC_W'(1) : PRESCALE;
          baud_d    = '0;
          bit_d     = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + PRESC_W'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q + PRESC_W'(1);
        end
      end
      StParity: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + PRESC_W'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // bit_q counts stop bits here: a second one only when two were requested.
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BitW'(1);
          end else begin
            bit_d   = '0;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + PRESC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so the line never sees decode glitches.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        busy_d = 1'b0;
        done_d = (state_q == StStop);
      end
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_d];
      StParity: tx_d = (^data_d) ^ par_typ_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX_OUT  = tx_q;
  assign BUSY    = busy_q;
  assign TX_DONE = done_q;

  a_done_not_busy: assert property (@(posedge CLK) disable iff (RST) TX_DONE |-> !BUSY);
  a_busy_state:    assert property (@(posedge CLK) disable iff (RST)
                                    BUSY == (state_q != StIdle));

endmodule
